multicycle_controller: RTL and testbench

//  Moore FSM controller for the multicycle RV32I-subset datapath. It decodes the latched

---
 rtl/multicycle_controller_pkg.sv | 90 +++++++++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller and its datapath muxes.
package multicycle_controller_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned RES_W   = 2;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned ALUOP_W = 2;

  // Opcodes handled by the controller
  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // Branch conditions
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  // Controller states (4-bit encoding)
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11
  } state_e;

  // Result mux select
  localparam logic [RES_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [RES_W-1:0] RES_DATA      = 2'b01;
  localparam logic [RES_W-1:0] RES_ALURESULT = 2'b10;
  localparam logic [RES_W-1:0] RES_IMMEXT    = 2'b11;

  // ALU operand selects
  localparam logic [SRC_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SRC_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SRC_W-1:0] SRCA_RD1   = 2'b10;
  localparam logic [SRC_W-1:0] SRCB_RD2   = 2'b00;
  localparam logic [SRC_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SRC_W-1:0] SRCB_FOUR  = 2'b10;

  // Immediate formats
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // ALU operations
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  // Coarse ALU operation requested by the FSM
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format implied by the opcode
  function automatic logic [IMM_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
    logic [IMM_W-1:0] imm;
    imm = IMM_I;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BRANCH:   imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      OP_LUI:      imm = IMM_U;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: coarse alu_op plus instruction fields -> alu_control.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [F3_W-1:0]    funct3_i,
  input  logic               op5_i,
  input  logic               funct7_5_i,
  output logic [ALUC_W-1:0]  alu_control_o
);

  // Map alu_op / funct3 to the ALU operation; only R-type with funct7_5 selects sub
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller sequencing fetch/decode/execute/writeback for the multicycle datapath.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [F3_W-1:0]   funct3,
  input  logic              funct7_5,
  input  logic              zero,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic [RES_W-1:0]  result_src,
  output logic [SRC_W-1:0]  alu_src_a,
  output logic [SRC_W-1:0]  alu_src_b,
  output logic [IMM_W-1:0]  imm_src,
  output logic [ALUC_W-1:0] alu_control
);

  state_e             state_q, state_d;
  logic [ALUOP_W-1:0] alu_op;
  logic               pc_update;
  logic               branch;
  logic               taken;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state output decode; reset forces every output low
  always_comb begin
    state_d    = S_FETCH;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    imm_src    = imm_src_of(op);

    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        state_d   = S_ALUWB;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        state_d   = S_ALUWB;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      alu_op     = ALUOP_ADD;
      pc_update  = 1'b0;
      branch     = 1'b0;
      imm_src    = IMM_I;
    end
  end

  // Branch condition follows the live zero flag
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    pc_write = pc_update | (branch & taken);
  end

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7_5_i    (funct7_5),
    .alu_control_o (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller against a phase-sequence model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;

  int checks = 0;
  int errors = 0;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, alu_control}
  logic [16:0] dut_vec;
  logic [16:0] exp_vec;
  logic        exp_valid = 1'b0;
  int          ph_idx = 0;
  logic [16:0] cap [0:7];

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  assign dut_vec = {pc_write, adr_src, mem_write, ir_write, reg_write,
                    result_src, alu_src_a, alu_src_b, imm_src, alu_control};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Phase letters of an instruction from its opcode:
  // F fetch, D decode, A address, R read, W write, L load-writeback, X reg exec,
  // I imm exec, B alu-writeback, J jal, Q branch, U lui
  function automatic string phases(input logic [6:0] o);
    case (o)
      7'b0000011: return "FDARL";
      7'b0100011: return "FDAW";
      7'b0110011: return "FDXB";
      7'b0010011: return "FDIB";
      7'b1101111: return "FDJB";
      7'b1100011: return "FDQ";
      7'b0110111: return "FDU";
      default:    return "FD";
    endcase
  endfunction

  // Expected output vector for one phase of an instruction
  function automatic logic [16:0] model(input byte ph, input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    int aop;
    logic [2:0] imm, alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; sa = 0; sb = 0; aop = 0;
    case (o)
      7'b0100011: imm = 3'd1;
      7'b1100011: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110111: imm = 3'd4;
      default:    imm = 3'd0;
    endcase
    case (ph)
      "F": begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      "D": begin sa = 1; sb = 1; end
      "A": begin sa = 2; sb = 1; end
      "R": begin adr = 1; end
      "W": begin adr = 1; mw = 1; end
      "L": begin rs = 1; rw = 1; end
      "X": begin sa = 2; sb = 0; aop = 2; end
      "I": begin sa = 2; sb = 1; aop = 2; end
      "B": begin rw = 1; end
      "J": begin sa = 1; sb = 2; pcw = 1; end
      "Q": begin sa = 2; aop = 1; pcw = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z); end
      "U": begin rs = 3; rw = 1; end
      default: ;
    endcase
    if (aop == 1) alu = 3'd1;
    else if (aop == 0) alu = 3'd0;
    else begin
      case (f3)
        3'd0: alu = (o[5] && f7) ? 3'd1 : 3'd0;
        3'd2: alu = 3'd5;
        3'd4: alu = 3'd4;
        3'd6: alu = 3'd3;
        3'd7: alu = 3'd2;
        default: alu = 3'd0;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  // Single compare process: every cycle with meaningful outputs
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("outputs", 32'(dut_vec), 32'(exp_vec));
      cap[ph_idx] = dut_vec;
    end
  end

  // Run one instruction starting in FETCH; abort_at >= 0 asserts rst in that phase
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int abort_at);
    string p;
    p = phases(o);
    op = o; funct3 = f3; funct7_5 = f7; zero = z;
    for (int i = 0; i < p.len(); i++) begin
      ph_idx = i;
      if (i == abort_at) begin
        rst = 1'b1;
        exp_vec = '0;
      end else begin
        exp_vec = model(p[i], o, f3, f7, z);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    exp_vec = '0; ph_idx = 0; exp_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    chk("reset_zero", 32'(cap[0]), 32'd0);
    rst = 1'b0;

    // lw
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b1, -1);
    chk("first_fetch_irw", 32'(cap[0][13]), 32'd1);
    chk("first_fetch_pcw", 32'(cap[0][16]), 32'd1);
    chk("first_fetch_rs", 32'(cap[0][11:10]), 32'd2);
    chk("first_fetch_srcb", 32'(cap[0][7:6]), 32'd2);
    chk("lw_c5_regwrite", 32'(cap[4][12]), 32'd1);
    chk("lw_c5_rs", 32'(cap[4][11:10]), 32'd1);
    chk("lw_c4_regwrite", 32'(cap[3][12]), 32'd0);
    chk("lw_memwrite", 32'({cap[0][14], cap[1][14], cap[2][14], cap[3][14], cap[4][14]}), 32'd0);

    // R-type sub and addi with same fields
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, -1);
    chk("sub_alu", 32'(cap[2][2:0]), 32'd1);
    chk("sub_wb_rw", 32'(cap[3][12]), 32'd1);
    chk("sub_wb_rs", 32'(cap[3][11:10]), 32'd0);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, -1);
    chk("addi_alu", 32'(cap[2][2:0]), 32'd0);

    // Other funct3 decodes
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b1, -1);
    run_instr(7'b0110011, 3'd2, 1'b0, 1'b0, -1);
    chk("slt_alu", 32'(cap[2][2:0]), 32'd5);
    run_instr(7'b0010011, 3'd4, 1'b0, 1'b0, -1);
    chk("xori_alu", 32'(cap[2][2:0]), 32'd4);
    run_instr(7'b0110011, 3'd6, 1'b1, 1'b0, -1);
    run_instr(7'b0010011, 3'd7, 1'b0, 1'b1, -1);
    chk("andi_alu", 32'(cap[2][2:0]), 32'd2);
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0, -1);

    // Branches
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, -1);
    chk("beq_taken", 32'(cap[2][16]), 32'd1);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, -1);
    chk("beq_not_taken", 32'(cap[2][16]), 32'd0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, -1);
    chk("bne_taken", 32'(cap[2][16]), 32'd1);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, -1);
    chk("bne_not_taken", 32'(cap[2][16]), 32'd0);
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b1, -1);
    chk("blt_never", 32'(cap[2][16]), 32'd0);

    // jal, lui, unknown op
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, -1);
    chk("jal_pcw", 32'(cap[2][16]), 32'd1);
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, -1);
    chk("lui_rs", 32'(cap[2][11:10]), 32'd3);
    chk("lui_rw", 32'(cap[2][12]), 32'd1);
    chk("lui_imm", 32'(cap[2][5:3]), 32'd4);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b1, -1);
    chk("unk_writes", 32'({cap[1][16], cap[1][14], cap[1][12]}), 32'd0);

    // sw completes, then sw aborted by reset in MEMWRITE
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, -1);
    chk("sw_memwrite", 32'(cap[3][14]), 32'd1);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3);
    chk("sw_abort_memwrite", 32'(cap[3][14]), 32'd0);

    // Reset in the middle of lw (MEMREAD) also returns to FETCH
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3);
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, -1);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
